// File: rtl/dq_delay_train_ctrl.sv
// Per-bit DQ read-eye trainer. Each bit's delay line is swept from tap 0 to TAP_MAX and the longest
// passing window is located. The line is then parked at the window centre and the per-bit result is latched.

module dq_delay_train_lane #(
  parameter int TAP_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sel,
  input  logic             load_p,
  input  logic             move_p,
  input  logic             dir_p,
  input  logic             clr_p,
  input  logic             start_clr,
  input  logic             store,
  input  logic             fail_set,
  input  logic [TAP_W-1:0] center_in,
  input  logic [TAP_W:0]   width_in,
  output logic             load,
  output logic             move,
  output logic             direction,
  output logic             clr_flags,
  output logic             fail,
  output logic [TAP_W-1:0] center,
  output logic [TAP_W:0]   width
);
  assign load      = sel & load_p;
  assign move      = sel & move_p;
  assign direction = sel & move_p & dir_p;
  assign clr_flags = sel & clr_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      fail   <= 1'b0;
      center <= '0;
      width  <= '0;
    end else if (start_clr) begin
      fail <= 1'b0;
    end else if (sel && store) begin
      center <= center_in;
      width  <= width_in;
      fail   <= fail_set;
    end
  end
endmodule

module dq_delay_train_ctrl #(
  parameter int NUM_BITS      = 8,
  parameter int TAP_W         = 7,
  parameter int TAP_MAX       = 127,
  parameter int SETTLE_CYCLES = 4,
  parameter int SAMPLE_CYCLES = 16,
  localparam int SEL_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                FAB_CLK,
  input  logic                SYNC_RST,
  input  logic                START,
  output logic                BUSY,
  output logic                DONE,
  output logic [NUM_BITS-1:0] DELAY_LINE_LOAD,
  output logic [NUM_BITS-1:0] DELAY_LINE_MOVE,
  output logic [NUM_BITS-1:0] DELAY_LINE_DIRECTION,
  output logic [NUM_BITS-1:0] EYE_MONITOR_CLEAR_FLAGS,
  input  logic [NUM_BITS-1:0] EYE_MONITOR_EARLY,
  input  logic [NUM_BITS-1:0] EYE_MONITOR_LATE,
  input  logic [NUM_BITS-1:0] DELAY_LINE_OUT_OF_RANGE,
  input  logic [SEL_W-1:0]    RESULT_SEL,
  output logic [TAP_W-1:0]    RESULT_CENTER,
  output logic [TAP_W:0]      RESULT_WIDTH,
  output logic [NUM_BITS-1:0] FAIL
);
  localparam int CMAX  = (SETTLE_CYCLES > SAMPLE_CYCLES) ? SETTLE_CYCLES : SAMPLE_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETTLE, S_CLEAR, S_SAMPLE, S_EVAL, S_STEP, S_CENTER, S_NEXT, S_DONE
  } state_t;

  state_t state, state_nxt;

  logic [SEL_W-1:0]    b;
  logic [TAP_W-1:0]    tap, run_start, best_start, run_start_nxt, cand_start, target;
  logic [TAP_W:0]      run_len, best_len, run_len_nxt, cand_len, best_end, win_sum;
  logic [CNT_W-1:0]    cnt;
  logic                err, oor;
  logic [NUM_BITS-1:0] sel_vec;
  logic                flag_cur, oor_cur, pass, last, close_run;
  logic                load_p, move_p, dir_p, clr_p, start_acc, store_res, fail_set;
  logic [TAP_W-1:0]    center_in;

  logic [NUM_BITS-1:0][TAP_W-1:0] res_center;
  logic [NUM_BITS-1:0][TAP_W:0]   res_width;

  always_comb begin
    for (int i = 0; i < NUM_BITS; i++) sel_vec[i] = (b == SEL_W'(i));
  end

  assign flag_cur  = |((EYE_MONITOR_EARLY | EYE_MONITOR_LATE) & sel_vec);
  assign oor_cur   = |(DELAY_LINE_OUT_OF_RANGE & sel_vec);
  assign start_acc = (state == S_IDLE) && START;

  // Window bookkeeping for the tap being evaluated; a run closes on a failing tap or at sweep end.
  always_comb begin
    pass          = !err;
    last          = (tap == TAP_W'(TAP_MAX)) || oor;
    run_len_nxt   = pass ? run_len + 1'b1 : '0;
    run_start_nxt = (pass && run_len == '0) ? tap : run_start;
    cand_len      = pass ? run_len_nxt : run_len;
    cand_start    = pass ? run_start_nxt : run_start;
    close_run     = !pass || last;
  end

  assign best_end = {1'b0, best_start} + best_len - 1'b1;
  assign win_sum  = {1'b0, best_start} + best_end;
  assign target   = win_sum[TAP_W:1];

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_p    = 1'b0;
    move_p    = 1'b0;
    dir_p     = 1'b0;
    clr_p     = 1'b0;
    case (state)
      S_IDLE:   if (START) state_nxt = S_LOAD;
      S_LOAD:   begin load_p = 1'b1; state_nxt = S_SETTLE; end
      S_SETTLE: if (cnt == CNT_W'(SETTLE_CYCLES - 1)) state_nxt = S_CLEAR;
      S_CLEAR:  begin clr_p = 1'b1; state_nxt = S_SAMPLE; end
      S_SAMPLE: if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) state_nxt = S_EVAL;
      S_EVAL:   state_nxt = last ? S_CENTER : S_STEP;
      S_STEP:   begin move_p = 1'b1; dir_p = 1'b1; state_nxt = S_SETTLE; end
      S_CENTER: begin
        // An end-stop still asserted from the top of the sweep is only acted on once we have moved.
        if (best_len == '0) begin
          load_p    = 1'b1;
          state_nxt = S_NEXT;
        end else if ((oor_cur && cnt != '0) || tap == target) begin
          state_nxt = S_NEXT;
        end else if (cnt == '0) begin
          move_p = 1'b1;
        end
      end
      S_NEXT:   state_nxt = (b == SEL_W'(NUM_BITS - 1)) ? S_DONE : S_LOAD;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign store_res = (state == S_CENTER) && (state_nxt == S_NEXT);
  assign fail_set  = (best_len == '0) || (oor_cur && cnt != '0);
  assign center_in = (best_len == '0) ? '0 : tap;

  always_ff @(posedge FAB_CLK) begin
    if (SYNC_RST) begin
      b          <= '0;
      tap        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      oor        <= 1'b0;
      run_len    <= '0;
      run_start  <= '0;
      best_len   <= '0;
      best_start <= '0;
    end else begin
      case (state)
        S_IDLE: if (START) b <= '0;
        S_LOAD: begin
          tap        <= '0;
          cnt        <= '0;
          run_len    <= '0;
          run_start  <= '0;
          best_len   <= '0;
          best_start <= '0;
        end
        S_SETTLE: cnt <= (cnt == CNT_W'(SETTLE_CYCLES - 1)) ? '0 : cnt + 1'b1;
        S_CLEAR: begin
          err <= 1'b0;
          oor <= 1'b0;
          cnt <= '0;
        end
        S_SAMPLE: begin
          err <= err | flag_cur;
          oor <= oor | oor_cur;
          cnt <= (cnt == CNT_W'(SAMPLE_CYCLES - 1)) ? '0 : cnt + 1'b1;
        end
        S_EVAL: begin
          cnt       <= '0;
          run_len   <= run_len_nxt;
          run_start <= run_start_nxt;
          // Strictly longer only, so the earliest of equal windows is kept.
          if (close_run && cand_len > best_len) begin
            best_len   <= cand_len;
            best_start <= cand_start;
          end
        end
        S_STEP: begin
          tap <= tap + 1'b1;
          cnt <= '0;
        end
        S_CENTER: begin
          if (best_len == '0) tap <= '0;
          else if (move_p)    tap <= tap - 1'b1;
          cnt <= (cnt == CNT_W'(SETTLE_CYCLES)) ? '0 : cnt + 1'b1;
        end
        S_NEXT: if (b != SEL_W'(NUM_BITS - 1)) b <= b + 1'b1;
        default: ;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_lane
    dq_delay_train_lane #(.TAP_W(TAP_W)) u_lane (
      .clk       (FAB_CLK),
      .rst       (SYNC_RST),
      .sel       (sel_vec[i]),
      .load_p    (load_p),
      .move_p    (move_p),
      .dir_p     (dir_p),
      .clr_p     (clr_p),
      .start_clr (start_acc),
      .store     (store_res),
      .fail_set  (fail_set),
      .center_in (center_in),
      .width_in  (best_len),
      .load      (DELAY_LINE_LOAD[i]),
      .move      (DELAY_LINE_MOVE[i]),
      .direction (DELAY_LINE_DIRECTION[i]),
      .clr_flags (EYE_MONITOR_CLEAR_FLAGS[i]),
      .fail      (FAIL[i]),
      .center    (res_center[i]),
      .width     (res_width[i])
    );
  end

  always_comb begin
    RESULT_CENTER = '0;
    RESULT_WIDTH  = '0;
    for (int i = 0; i < NUM_BITS; i++) begin
      if (RESULT_SEL == SEL_W'(i)) begin
        RESULT_CENTER = res_center[i];
        RESULT_WIDTH  = res_width[i];
      end
    end
  end

  assign BUSY = (state != S_IDLE) && (state != S_DONE);
  assign DONE = (state == S_DONE);
endmodule

// File: tb/tb_dq_delay_train_ctrl.sv
// Directed bench: behavioural delay-line/eye model per bit, expected results queued per run and
// compared after DONE.

module tb_dq_delay_train_ctrl;
  localparam int NB = 2, TW = 7, TMAX = 15, SC = 2, SMC = 4, PER_TAP = SC + SMC + 3;

  logic          FAB_CLK = 1'b0;
  logic          SYNC_RST, START;
  logic          BUSY, DONE;
  logic [NB-1:0] DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS;
  logic [NB-1:0] EYE_MONITOR_EARLY, EYE_MONITOR_LATE, DELAY_LINE_OUT_OF_RANGE, FAIL;
  logic [0:0]    RESULT_SEL;
  logic [TW-1:0] RESULT_CENTER;
  logic [TW:0]   RESULT_WIDTH;

  dq_delay_train_ctrl #(.NUM_BITS(NB), .TAP_W(TW), .TAP_MAX(TMAX),
                        .SETTLE_CYCLES(SC), .SAMPLE_CYCLES(SMC)) dut (
    .FAB_CLK(FAB_CLK), .SYNC_RST(SYNC_RST), .START(START), .BUSY(BUSY), .DONE(DONE),
    .DELAY_LINE_LOAD(DELAY_LINE_LOAD), .DELAY_LINE_MOVE(DELAY_LINE_MOVE),
    .DELAY_LINE_DIRECTION(DELAY_LINE_DIRECTION), .EYE_MONITOR_CLEAR_FLAGS(EYE_MONITOR_CLEAR_FLAGS),
    .EYE_MONITOR_EARLY(EYE_MONITOR_EARLY), .EYE_MONITOR_LATE(EYE_MONITOR_LATE),
    .DELAY_LINE_OUT_OF_RANGE(DELAY_LINE_OUT_OF_RANGE), .RESULT_SEL(RESULT_SEL),
    .RESULT_CENTER(RESULT_CENTER), .RESULT_WIDTH(RESULT_WIDTH), .FAIL(FAIL)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct {
    logic [TW-1:0] c;
    logic [TW:0]   w;
    logic          f;
  } exp_t;
  exp_t sb[$];

  // Eye model: per-bit pass mask over taps, end-stop at or above oor_tap.
  logic [127:0] pass_mask [NB];
  int           oor_tap   [NB];
  logic [TW-1:0] tap_m    [NB];

  always_comb begin
    for (int i = 0; i < NB; i++) begin
      EYE_MONITOR_EARLY[i]       = !pass_mask[i][tap_m[i]] && (tap_m[i] < 8);
      EYE_MONITOR_LATE[i]        = !pass_mask[i][tap_m[i]] && (tap_m[i] >= 8);
      DELAY_LINE_OUT_OF_RANGE[i] = (int'(tap_m[i]) >= oor_tap[i]);
    end
  end

  int cyc = 0, done_cnt = 0, sel_err = 0, space_err = 0, min_err = 0, last_mv = -100;
  int up_cnt [NB], dn_cnt [NB], ld_cnt [NB], last_up [NB];

  initial begin
    for (int i = 0; i < NB; i++) begin
      tap_m[i] = '0; up_cnt[i] = 0; dn_cnt[i] = 0; ld_cnt[i] = 0; last_up[i] = -1;
      pass_mask[i] = '0; oor_tap[i] = 1000;
    end
  end

  always @(negedge FAB_CLK) begin
    cyc++;
    if (DONE) done_cnt++;
    if ($countones({DELAY_LINE_LOAD, DELAY_LINE_MOVE, EYE_MONITOR_CLEAR_FLAGS}) > 1) sel_err++;
    if ((DELAY_LINE_DIRECTION & ~DELAY_LINE_MOVE) != '0) sel_err++;
    for (int i = 0; i < NB; i++) begin
      if (DELAY_LINE_LOAD[i]) begin
        ld_cnt[i]++; tap_m[i] = '0; last_up[i] = -1;
      end else if (DELAY_LINE_MOVE[i]) begin
        if (cyc - last_mv < SC + 1) min_err++;
        last_mv = cyc;
        if (DELAY_LINE_DIRECTION[i]) begin
          up_cnt[i]++; tap_m[i] = tap_m[i] + 1'b1;
          if (last_up[i] >= 0 && cyc - last_up[i] != PER_TAP) space_err++;
          last_up[i] = cyc;
        end else begin
          dn_cnt[i]++; tap_m[i] = tap_m[i] - 1'b1;
        end
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  int up_s [NB], dn_s [NB], ld_s [NB];
  int done_s;

  task automatic snap();
    up_s = up_cnt; dn_s = dn_cnt; ld_s = ld_cnt; done_s = done_cnt;
  endtask

  task automatic pulse_start();
    @(negedge FAB_CLK); START = 1'b1;
    @(negedge FAB_CLK); START = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge FAB_CLK);
      if (DONE) ok = 1'b1;
    end
    check({tag, "_done_seen"}, ok, 1);
    repeat (3) @(negedge FAB_CLK);
  endtask

  task automatic check_results(input string tag, input logic [NB-1:0] fail_exp);
    exp_t e;
    check({tag, "_fail_vec"}, FAIL, fail_exp);
    for (int i = 0; i < NB; i++) begin
      if (sb.size() == 0) begin
        check({tag, "_sb_empty"}, sb.size(), 1);
      end else begin
        e = sb.pop_front();
        RESULT_SEL = i[0:0];
        #1;
        check($sformatf("%s_center%0d", tag, i), RESULT_CENTER, e.c);
        check($sformatf("%s_width%0d", tag, i), RESULT_WIDTH, e.w);
        check($sformatf("%s_fail%0d", tag, i), FAIL[i], e.f);
      end
    end
  endtask

  task automatic push(input int c, input int w, input bit f);
    exp_t e;
    e.c = c[TW-1:0]; e.w = w[TW:0]; e.f = f;
    sb.push_back(e);
  endtask

  task automatic set_win(input int bit_i, input int lo, input int hi);
    for (int t = lo; t <= hi; t++) pass_mask[bit_i][t] = 1'b1;
  endtask

  initial begin
    SYNC_RST = 1'b1; START = 1'b0; RESULT_SEL = '0;
    repeat (3) @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    @(negedge FAB_CLK);
    check("rst_busy", BUSY, 0);
    check("rst_done", DONE, 0);
    check("rst_fail", FAIL, 0);
    check("rst_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}, 0);
    check("rst_center", RESULT_CENTER, 0);
    check("rst_width", RESULT_WIDTH, 0);

    // Run A: single windows / two windows; a stray START mid-run must be ignored.
    pass_mask[0] = '0; pass_mask[1] = '0;
    set_win(0, 4, 10);
    set_win(1, 2, 3); set_win(1, 8, 12);
    push(7, 7, 0); push(10, 5, 0);
    snap();
    pulse_start();
    check("a_busy", BUSY, 1);
    repeat (40) @(negedge FAB_CLK);
    pulse_start();
    wait_done("a");
    check("a_done_once", done_cnt - done_s, 1);
    check("a_busy_after", BUSY, 0);
    check("a_up0", up_cnt[0] - up_s[0], 15);
    check("a_dn0", dn_cnt[0] - dn_s[0], 8);
    check("a_up1", up_cnt[1] - up_s[1], 15);
    check("a_dn1", dn_cnt[1] - dn_s[1], 5);
    check("a_ld1", ld_cnt[1] - ld_s[1], 1);
    check_results("a", 2'b00);

    // Run B: equal windows keep the first; bit1 never passes.
    pass_mask[0] = '0; pass_mask[1] = '0;
    set_win(0, 1, 3); set_win(0, 6, 8);
    push(2, 3, 0); push(0, 0, 1);
    snap();
    pulse_start();
    wait_done("b");
    check("b_done_once", done_cnt - done_s, 1);
    check("b_ld1", ld_cnt[1] - ld_s[1], 2);
    check("b_dn1", dn_cnt[1] - dn_s[1], 0);
    check("b_tap1_parked", tap_m[1], 0);
    check_results("b", 2'b10);

    // Reset during bit1's SAMPLE phase.
    pass_mask[0] = '0; pass_mask[1] = '0;
    set_win(0, 4, 15); oor_tap[0] = 9;
    set_win(1, 0, 15);
    pulse_start();
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
        @(negedge FAB_CLK);
        if (EYE_MONITOR_CLEAR_FLAGS[1]) seen = 1'b1;
      end
      check("r_clr1_seen", seen, 1);
    end
    @(negedge FAB_CLK);
    SYNC_RST = 1'b1;
    @(negedge FAB_CLK);
    SYNC_RST = 1'b0;
    RESULT_SEL = 1'b0;
    #1;
    check("r_busy", BUSY, 0);
    check("r_pulses", {DELAY_LINE_LOAD, DELAY_LINE_MOVE, DELAY_LINE_DIRECTION, EYE_MONITOR_CLEAR_FLAGS}, 0);
    check("r_fail", FAIL, 0);
    check("r_center0", RESULT_CENTER, 0);
    snap();
    repeat (20) @(negedge FAB_CLK);
    check("r_quiet", (ld_cnt[0] - ld_s[0]) + (ld_cnt[1] - ld_s[1]) + (up_cnt[1] - up_s[1]), 0);

    // Run C: end-stop stops bit0's sweep at tap 9; bit1 passes every tap.
    push(6, 6, 0); push(7, 16, 0);
    snap();
    pulse_start();
    @(negedge FAB_CLK);
    check("c_first_load_bit0", ld_cnt[0] - ld_s[0], 1);
    wait_done("c");
    check("c_up0", up_cnt[0] - up_s[0], 9);
    check("c_dn0", dn_cnt[0] - dn_s[0], 3);
    check("c_dn1", dn_cnt[1] - dn_s[1], 8);
    check_results("c", 2'b00);

    check("spacing_per_tap", space_err, 0);
    check("move_min_spacing", min_err, 0);
    check("one_bit_driven", sel_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: observed timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/dq_delay_train_ctrl.md
Name: dq_delay_train_ctrl

Overview:
Parametrised per-bit read-training sequencer for the DDR3 PHY lanes. It drives the IOD dynamic delay-line and eye-monitor controls for NUM_BITS DQ bits, one bit at a time. For each bit it sweeps taps 0..TAP_MAX and finds the longest contiguous passing window. It then parks the delay line at the window centre and reports per-bit centre, width and fail status to the training FSM.

Parameters:
NUM_BITS, 8, number of DQ bits/IODs controlled (1..16)
TAP_W, 7, tap counter width
TAP_MAX, 127, last tap swept (must be < 2**TAP_W)
SETTLE_CYCLES, 4, wait cycles after any delay-line load/move before sampling (>=1)
SAMPLE_CYCLES, 16, cycles the eye-monitor flags are observed per tap (>=1)

Ports:
FAB_CLK  in  1  fabric clock; all logic on rising edge
SYNC_RST  in  1  synchronous, active-high reset
START  in  1  one-cycle pulse; begins training of all bits
BUSY  out  1  high from the cycle after an accepted START until DONE
DONE  out  1  one-cycle pulse when the last bit is centred
DELAY_LINE_LOAD  out  NUM_BITS  one-cycle pulse; resets the selected bit's delay to tap 0
DELAY_LINE_MOVE  out  NUM_BITS  one-cycle pulse; moves the selected bit by one tap
DELAY_LINE_DIRECTION  out  NUM_BITS  1 = increase delay, 0 = decrease; valid with MOVE
EYE_MONITOR_CLEAR_FLAGS  out  NUM_BITS  one-cycle pulse; clears the early/late sticky flags
EYE_MONITOR_EARLY  in  NUM_BITS  sticky early flag per bit
EYE_MONITOR_LATE  in  NUM_BITS  sticky late flag per bit
DELAY_LINE_OUT_OF_RANGE  in  NUM_BITS  per-bit delay-line end-stop
RESULT_SEL  in  $clog2(NUM_BITS) (min 1)  bit index for readout
RESULT_CENTER  out  TAP_W  final tap of the selected bit (combinational readout of registers)
RESULT_WIDTH  out  TAP_W+1  passing-window width of the selected bit
FAIL  out  NUM_BITS  1 = no passing tap found for that bit

Behaviour:
- Reset: state IDLE; all pulse outputs, BUSY, DONE and FAIL = 0; result registers = 0; bit index = 0; tap counter = 0.
- Only the bit at the current index `b` is driven. The other bits of each control vector stay at 0.
- States and transitions:
  - IDLE: START=1 -> LOAD. START while not in IDLE is ignored.
  - LOAD: pulse LOAD[b]; tap = 0; run/best registers cleared -> SETTLE.
  - SETTLE: wait SETTLE_CYCLES -> CLEAR.
  - CLEAR: pulse CLEAR_FLAGS[b] -> SAMPLE.
  - SAMPLE: wait SAMPLE_CYCLES; accumulate OR of EARLY[b]|LATE[b] -> EVAL.
  - EVAL: tap passes if the accumulated OR is 0.
    - Pass: run_len++; run_start = tap if run_len was 0.
    - Fail: close the run.
    - A closed run replaces best only if strictly longer, so the first of two equal windows wins.
    - tap == TAP_MAX, or OUT_OF_RANGE[b] sampled high in SAMPLE: close any open run -> CENTER.
    - Otherwise -> STEP.
  - STEP: pulse MOVE[b] with DIRECTION[b]=1; tap++ -> SETTLE.
  - CENTER: target = (best_start + best_end) >> 1, computed in TAP_W+1 bits and floored.
    - Issue one MOVE[b] with DIRECTION[b]=0 every (SETTLE_CYCLES+1) cycles, tap--, until tap == target.
    - Best width 0: set FAIL[b], pulse LOAD[b], target = 0.
    - Store center/width -> NEXT.
  - NEXT: b == NUM_BITS-1 -> DONE, else b++ -> LOAD.
  - DONE: DONE=1 for one cycle, BUSY=0 -> IDLE. Results hold until the next accepted START, which clears FAIL.
- Cost per swept tap: SETTLE_CYCLES + SAMPLE_CYCLES + 3 cycles. MOVE pulses are never closer together than SETTLE_CYCLES+1 cycles.
- OUT_OF_RANGE asserted during CENTER: abort moves, set FAIL[b], store the current tap as center.
- SYNC_RST at any time, including mid-sweep: next cycle equals the reset state. No pending pulse is emitted.
- RESULT_SEL >= NUM_BITS: RESULT_CENTER and RESULT_WIDTH read 0.

Test Plan:
- NUM_BITS=2, TAP_MAX=15, SETTLE=2, SAMPLE=4. Bit0 eye model passes taps 4..10 -> RESULT_CENTER[0]=7, WIDTH=7, exactly 15 up-moves then 8 down-moves, FAIL=00.
- Bit1 passes taps 2..3 and 8..12 -> center 10, width 5. Equal windows 1..3 and 6..8 -> first kept, center 2.
- Bit1 never passes -> FAIL[1]=1, one extra LOAD[1] pulse in CENTER, center 0, width 0. DONE still pulses once.
- Bit0 passes 4..15, OUT_OF_RANGE[0] rises at tap 9 -> sweep stops, window 4..9, center 6, width 6, no up-move past tap 9.
- Assert SYNC_RST during SAMPLE of bit1 -> next cycle BUSY=0, all pulses 0, FAIL=00. A fresh START retrains from bit0.
- START pulsed while BUSY -> ignored: single DONE, pulse counts unchanged. Check per-tap spacing = SETTLE+SAMPLE+3 cycles.
